// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 size codes, FSM state type and alignment helper
//               for the sized data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RISC-V funct3 load/store size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Halfwords need an even byte address, words a word-aligned address.
  // Bytes (and illegal codes, faulted elsewhere) never count as misaligned.
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (size)
      F3_H, F3_HU: mis = lane[0];
      F3_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_sized_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_sized_if
// Description : Request/response bundle for the sized data memory. The
//               master issues valid/ready requests and receives a registered
//               one-cycle response plus the clear-sweep busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering. Store side produces byte
//               enables and lane-replicated write data; load side selects
//               the addressed lane(s), shifts them to bit 0 and extends.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store path: replicate the low bits into every lane, enable only targets
  always_comb begin
    be       = 4'b0000;
    wdata_sh = 32'h0;
    case (size)
      F3_B: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
      end
      F3_H: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
      end
      default: begin
        be       = 4'b0000;
        wdata_sh = 32'h0;
      end
    endcase
  end

  // Load path: pick the addressed byte/halfword and extend to 32 bits
  always_comb begin
    w_byte    = rword[8*lane +: 8];
    w_half    = lane[1] ? rword[31:16] : rword[15:0];
    rdata_ext = 32'h0;
    case (size)
      F3_B:    rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   rdata_ext = {24'h0, w_byte};
      F3_H:    rdata_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   rdata_ext = {16'h0, w_half};
      F3_W:    rdata_ext = rword;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_sized
// Description : Byte-addressed little-endian data memory with RISC-V sized
//               loads/stores, fault reporting, a registered 1-cycle response
//               and a post-reset sweep that zeroes one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int PROTECT_ZERO = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_sized_if.slave  bus
);

  localparam int ADDR_IDX = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_IDX-1:0] c_LAST_IDX = ADDR_IDX'(DEPTH_WORDS - 1);

  logic [31:0]         mem [DEPTH_WORDS];

  state_t              r_state;
  logic [ADDR_IDX-1:0] r_clear_idx;

  logic [ADDR_IDX-1:0] w_idx;
  logic [1:0]          w_lane;
  logic                w_accept;
  logic                w_illegal_size;
  logic                w_range_fault;
  logic                w_fault;
  logic                w_zero_drop;
  logic                w_store_ok;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata_sh;
  logic [31:0]         w_rdata_ext;

  assign w_idx          = bus.req_addr[ADDR_IDX+1:2];
  assign w_lane         = bus.req_addr[1:0];
  assign w_accept       = bus.req_valid && bus.req_ready;
  assign w_illegal_size = (bus.req_size == 3'b011) || (bus.req_size == 3'b110) ||
                          (bus.req_size == 3'b111);
  assign w_range_fault  = (bus.req_addr[31:ADDR_IDX+2] != '0);
  assign w_fault        = w_illegal_size || w_range_fault ||
                          is_misaligned(bus.req_size, w_lane);
  assign w_zero_drop    = (PROTECT_ZERO != 0) && (w_idx == '0);
  assign w_store_ok     = w_accept && bus.req_write && !w_fault && !w_zero_drop;

  dmem_lane_align u_align (
    .size      (bus.req_size),
    .lane      (w_lane),
    .wdata     (bus.req_wdata),
    .rword     (mem[w_idx]),
    .be        (w_be),
    .wdata_sh  (w_wdata_sh),
    .rdata_ext (w_rdata_ext)
  );

  // Array write port: clear sweep has priority, otherwise byte-lane stores
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      mem[r_clear_idx] <= 32'h0;
    end else if (w_store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with clear counter and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= CLEAR;
      r_clear_idx   <= '0;
      bus.req_ready <= 1'b0;
      bus.busy      <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= 32'h0;
          bus.rsp_fault <= 1'b0;
          r_clear_idx   <= r_clear_idx + 1'b1;
          if (r_clear_idx == c_LAST_IDX) begin
            r_state       <= IDLE;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        IDLE: begin
          bus.rsp_valid <= w_accept;
          bus.rsp_fault <= w_accept && w_fault;
          // Only a clean load returns data; stores and faults read as zero
          bus.rsp_rdata <= (w_accept && !bus.req_write && !w_fault) ?
                           w_rdata_ext : 32'h0;
        end
        default: begin
          r_state       <= CLEAR;
          r_clear_idx   <= '0;
          bus.req_ready <= 1'b0;
          bus.busy      <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= 32'h0;
          bus.rsp_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_sized.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_sized
// Description : Directed self-checking bench for data_mem_sized with
//               DEPTH_WORDS=16, one instance with word-0 protection and one
//               without, driven with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_sized;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  data_mem_sized_if bus ();
  data_mem_sized_if bus_np ();

  data_mem_sized #(.DEPTH_WORDS(16), .PROTECT_ZERO(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_mem_sized #(.DEPTH_WORDS(16), .PROTECT_ZERO(0)) dut_np (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid    = v;  bus_np.req_valid = v;
    bus.req_write    = w;  bus_np.req_write = w;
    bus.req_size     = sz; bus_np.req_size  = sz;
    bus.req_addr     = a;  bus_np.req_addr  = a;
    bus.req_wdata    = d;  bus_np.req_wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, accepted at the next edge; response is visible afterwards
  task automatic req(input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, w, sz, a, d);
    tick();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  // Counts cycles until ready, bounded so a stuck sweep still terminates
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_busy",  {31'h0, bus.busy},      32'h1);
    chk("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rdata", bus.rsp_rdata,          32'h0);
    chk("rst_fault", {31'h0, bus.rsp_fault}, 32'h0);

    // Sweep lasts exactly DEPTH_WORDS cycles
    reset = 1'b0;
    chk("sweep_busy_start", {31'h0, bus.busy}, 32'h1);
    wait_ready(cyc);
    chk("sweep_len", cyc, 32'd16);
    chk("sweep_busy_end", {31'h0, bus.busy}, 32'h0);

    // Last in-range word reads zero
    req(1'b0, 3'b010, 32'h3C, 32'h0);
    chk("lw3c_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("lw3c_data",  bus.rsp_rdata, 32'h0);
    chk("lw3c_fault", {31'h0, bus.rsp_fault}, 32'h0);
    tick();
    chk("idle_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // Sized stores then loads
    req(1'b1, 3'b010, 32'h10, 32'h11223344);
    chk("sw_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("sw_rdata", bus.rsp_rdata, 32'h0);
    req(1'b1, 3'b000, 32'h11, 32'h000000AA);
    req(1'b1, 3'b001, 32'h12, 32'h0000BEEF);
    req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw10", bus.rsp_rdata, 32'hBEEFAA44);
    req(1'b0, 3'b000, 32'h11, 32'h0);
    chk("lb11", bus.rsp_rdata, 32'hFFFFFFAA);
    req(1'b0, 3'b100, 32'h11, 32'h0);
    chk("lbu11", bus.rsp_rdata, 32'h000000AA);
    req(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh12", bus.rsp_rdata, 32'hFFFFBEEF);
    req(1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu12", bus.rsp_rdata, 32'h0000BEEF);
    chk("lhu12_valid", {31'h0, bus.rsp_valid}, 32'h1);

    // Faults
    req(1'b0, 3'b010, 32'h6, 32'h0);
    chk("lw6_fault", {31'h0, bus.rsp_fault}, 32'h1);
    chk("lw6_rdata", bus.rsp_rdata, 32'h0);
    chk("lw6_valid", {31'h0, bus.rsp_valid}, 32'h1);
    req(1'b1, 3'b010, 32'h4, 32'h12345678);
    req(1'b1, 3'b001, 32'h5, 32'h0000FFFF);
    chk("sh5_fault", {31'h0, bus.rsp_fault}, 32'h1);
    req(1'b0, 3'b010, 32'h4, 32'h0);
    chk("sh5_unchanged", bus.rsp_rdata, 32'h12345678);
    chk("lw4_fault", {31'h0, bus.rsp_fault}, 32'h0);
    req(1'b0, 3'b011, 32'h8, 32'h0);
    chk("size011_fault", {31'h0, bus.rsp_fault}, 32'h1);
    req(1'b0, 3'b010, 32'h40, 32'h0);
    chk("lw40_fault", {31'h0, bus.rsp_fault}, 32'h1);
    chk("lw40_rdata", bus.rsp_rdata, 32'h0);

    // Word-0 protection
    req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF);
    chk("sw0_fault", {31'h0, bus.rsp_fault}, 32'h0);
    req(1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw0_prot", bus.rsp_rdata, 32'h0);
    chk("lw0_prot_fault", {31'h0, bus.rsp_fault}, 32'h0);
    chk("lw0_noprot", bus_np.rsp_rdata, 32'hDEADBEEF);

    // Back-to-back store then load to the same word
    drive(1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("b2b_st_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("b2b_st_rdata", bus.rsp_rdata, 32'h0);
    tick();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("b2b_ld_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("b2b_ld_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    tick();
    chk("b2b_after_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // Reset mid-sweep restarts the full sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (7) tick();
    chk("mid_busy", {31'h0, bus.busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h0);
    tick();
    reset = 1'b0;
    wait_ready(cyc);
    chk("mid_sweep_len", cyc, 32'd16);

    // Asynchronous reset during an outstanding load response
    req(1'b0, 3'b010, 32'h4, 32'h0);
    chk("pre_async_valid", {31'h0, bus.rsp_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_valid", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    reset = 1'b0;
    wait_ready(cyc);
    chk("async_sweep_len", cyc, 32'd16);
    req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("cleared_lw10", bus.rsp_rdata, 32'h0);
    chk("cleared_lw10_np", bus_np.rsp_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Byte-addressed, little-endian data memory for the single-cycle/pipelined core.
- Supports RISC-V load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes, sign/zero extension, and misalignment and range fault reporting.
- Uses a valid/ready request and a registered 1-cycle response.
- After reset, a hardware sweep zeroes the array one word per cycle, so there is no single-cycle bulk clear.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- PROTECT_ZERO, 1, when 1, stores to word 0 are silently dropped.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bits are used for B/H.
- rsp_valid  out  1  response valid, one-cycle pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  request was rejected (misaligned, out of range, or illegal size).
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - state=CLEAR, clear_idx=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, busy=1.
- FSM states:
  - CLEAR: write 0 to word clear_idx, then clear_idx++. Go to IDLE in the cycle after word DEPTH_WORDS-1 is written, so CLEAR lasts exactly DEPTH_WORDS cycles after reset deasserts.
  - IDLE: req_ready=1, busy=0.
  - There is no other state.
- Reset asserted mid-sweep: the sweep restarts from index 0.
- Accept condition: req_valid && req_ready, sampled at the clk edge. One request per cycle; IDLE never stalls.
- Word index = req_addr[ADDR_IDX+1:2], where ADDR_IDX=$clog2(DEPTH_WORDS). Byte lane = req_addr[1:0].
- Fault conditions (any one):
  - size H/HU with addr[0]=1;
  - size W with addr[1:0]!=0;
  - req_size in {011,110,111};
  - req_addr[31:ADDR_IDX+2] != 0.
- On a fault: no memory update; next cycle rsp_valid=1, rsp_fault=1, rsp_rdata=0.
- Store:
  - byte enables: SB = 1 lane, SH = lanes {addr[1],0}..+1, SW = all 4 lanes;
  - data is replicated into the target lanes;
  - memory is updated at the accept edge;
  - next cycle rsp_valid=1, rsp_fault=0, rsp_rdata=0;
  - word 0 with PROTECT_ZERO=1: no update and no fault.
- Load:
  - array read at the accept edge, registered;
  - next cycle rsp_valid=1 with the selected lane(s) shifted to bit 0;
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- Latency is 1 cycle for every accepted request. rsp_valid is 0 in any cycle not following an accept.
- Back-to-back store then load to the same word: the load returns the new data, because the write commits at the earlier edge.
- A store and a load are never accepted in the same cycle; there is a single port.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - enum state_t {CLEAR, IDLE};
  - function is_misaligned(size, addr[1:0]).
- Combinational sub-module dmem_lane_align:
  - store path: size, lane, wdata -> byte enables[3:0], shifted wdata;
  - load path: size, lane, word -> extended rdata.
- Top level holds the FSM, clear counter, array, and response registers.

Test Plan:
- Reset sweep: pulse reset, DEPTH_WORDS=16 -> busy=1 and req_ready=0 for exactly 16 cycles after deassert, then ready=1. LW at 0x3C returns 0x00000000.
- Sized stores/loads: SW 0x11223344 at 0x10, SB 0xAA at 0x11, SH 0xBEEF at 0x12 -> LW 0x10 = 0xBEEFAA44, LB 0x11 = 0xFFFFFFAA, LBU 0x11 = 0x000000AA, LH 0x12 = 0xFFFFBEEF, LHU 0x12 = 0x0000BEEF. Each response arrives exactly 1 cycle after accept.
- Faults:
  - LW 0x0000_0006 -> rsp_fault=1, rdata=0;
  - SH 0x0000_0005 -> fault=1 and memory unchanged;
  - size 3'b011 -> fault;
  - LW 0x0000_0040 (DEPTH_WORDS=16) -> fault.
- Zero protect: SW 0xDEADBEEF at 0x0, then LW 0x0 -> 0x00000000, fault=0. With PROTECT_ZERO=0 -> 0xDEADBEEF.
- Back-to-back: SW 0xCAFEF00D at 0x20 in cycle n, LW 0x20 in cycle n+1 -> rsp_rdata=0xCAFEF00D in cycle n+2. rsp_valid stays high for 2 consecutive cycles.
- Reset mid-sweep: assert reset at clear_idx=7, release -> sweep restarts at 0 and lasts the full DEPTH_WORDS cycles. An asynchronous reset during an outstanding load clears rsp_valid immediately.
